// File: rtl/bank_biu_wbu_if.sv
// Bus bundle for the bank write-back unit.
// Groups the HTU eviction request, the SRAM half-line beat channel, the AXI3
// AW/W/B channels and the status outputs.
// Modport "master" is the WBU itself, because it is the AXI3 write master.
// Modport "slave" is the surrounding logic: HTU, SRAM controller and AXI
// interconnect.
interface bank_biu_wbu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // HTU eviction request
  logic                  htu_wbu_awvalid;
  logic                  htu_wbu_awready;
  logic [ADDR_WIDTH-6:0] htu_wbu_awaddr;
  logic [5:0]            htu_wbu_set_way;

  // SRAM controller half-line beats
  logic                  sc_wbu_valid;
  logic                  sc_wbu_ready;
  logic [127:0]          sc_wbu_data;
  logic                  sc_wbu_offset;
  logic                  sc_wbu_all_offset;
  logic [6:0]            sc_wbu_set_way_offset;

  // AXI3 write address
  logic                  wbu_axi3_awvalid;
  logic                  wbu_axi3_awready;
  logic [ID_WIDTH-1:0]   wbu_axi3_awid;
  logic [ADDR_WIDTH-1:0] wbu_axi3_awaddr;
  logic [3:0]            wbu_axi3_awlen;
  logic [2:0]            wbu_axi3_awsize;
  logic [1:0]            wbu_axi3_awburst;

  // AXI3 write data
  logic                  wbu_axi3_wvalid;
  logic                  wbu_axi3_wready;
  logic [ID_WIDTH-1:0]   wbu_axi3_wid;
  logic [DATA_WIDTH-1:0] wbu_axi3_wdata;
  logic [STRB_WIDTH-1:0] wbu_axi3_wstrb;
  logic                  wbu_axi3_wlast;

  // AXI3 write response
  logic                  wbu_axi3_bvalid;
  logic                  wbu_axi3_bready;
  logic [ID_WIDTH-1:0]   wbu_axi3_bid;
  logic [1:0]            wbu_axi3_bresp;

  // Status
  logic                  wbu_busy;
  logic                  wbu_done;
  logic                  wbu_err;

  modport master (
    input  htu_wbu_awvalid, htu_wbu_awaddr, htu_wbu_set_way,
    output htu_wbu_awready,
    input  sc_wbu_valid, sc_wbu_data, sc_wbu_offset, sc_wbu_all_offset,
    input  sc_wbu_set_way_offset,
    output sc_wbu_ready,
    output wbu_axi3_awvalid, wbu_axi3_awid, wbu_axi3_awaddr, wbu_axi3_awlen,
    output wbu_axi3_awsize, wbu_axi3_awburst,
    input  wbu_axi3_awready,
    output wbu_axi3_wvalid, wbu_axi3_wid, wbu_axi3_wdata, wbu_axi3_wstrb,
    output wbu_axi3_wlast,
    input  wbu_axi3_wready,
    input  wbu_axi3_bvalid, wbu_axi3_bid, wbu_axi3_bresp,
    output wbu_axi3_bready,
    output wbu_busy, wbu_done, wbu_err
  );

  modport slave (
    output htu_wbu_awvalid, htu_wbu_awaddr, htu_wbu_set_way,
    input  htu_wbu_awready,
    output sc_wbu_valid, sc_wbu_data, sc_wbu_offset, sc_wbu_all_offset,
    output sc_wbu_set_way_offset,
    input  sc_wbu_ready,
    input  wbu_axi3_awvalid, wbu_axi3_awid, wbu_axi3_awaddr, wbu_axi3_awlen,
    input  wbu_axi3_awsize, wbu_axi3_awburst,
    output wbu_axi3_awready,
    input  wbu_axi3_wvalid, wbu_axi3_wid, wbu_axi3_wdata, wbu_axi3_wstrb,
    input  wbu_axi3_wlast,
    output wbu_axi3_wready,
    output wbu_axi3_bvalid, wbu_axi3_bid, wbu_axi3_bresp,
    input  wbu_axi3_bready,
    input  wbu_busy, wbu_done, wbu_err
  );
endinterface

// File: rtl/bank_biu_wbu.sv
// Bank write-back unit.
// Takes one dirty-eviction request, then gathers the victim line as one or
// two 128-bit halves. It then issues a single-beat AXI3 AW/W pair and waits
// for B before accepting the next eviction.
// Optional build macro: WBU_TIMEOUT_EN adds a B-response watchdog of
// TIMEOUT_CYCLES. When it fires it raises err and returns to IDLE.
module bank_biu_wbu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 256,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           clk_i,
  input logic           rst_i,
  bank_biu_wbu_if.master bus
);
  localparam int HALF_W = DATA_WIDTH / 2;
  localparam int HALF_B = STRB_WIDTH / 2;

  typedef enum logic [1:0] {IDLE, COLLECT, SEND, RESP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-6:0] addr_reg;
  logic [5:0]            set_way_reg;
  logic [1:0]            mask_reg;
  logic                  all_offset_reg;
  logic                  aw_pend_reg;
  logic                  w_pend_reg;
  logic                  err_reg;

  logic                  req_fire;
  logic                  beat_fire;
  logic                  tag_match;
  logic                  store_beat;
  logic                  beat_all;
  logic [1:0]            mask_upd;
  logic                  line_done;
  logic                  aw_left;
  logic                  w_left;
  logic                  b_fire;
  logic                  b_bad;
  logic [ID_WIDTH-1:0]   id_w;
  logic [DATA_WIDTH-1:0] wdata_w;
  logic [STRB_WIDTH-1:0] wstrb_w;
  logic                  unused_tag_bit;

  // The tag's low bit repeats sc_wbu_offset; only the set/way part is checked.
  assign unused_tag_bit = bus.sc_wbu_set_way_offset[0];

  assign req_fire   = (state == IDLE) && bus.htu_wbu_awvalid;
  assign beat_fire  = (state == COLLECT) && bus.sc_wbu_valid;
  assign tag_match  = (bus.sc_wbu_set_way_offset[6:1] == set_way_reg);
  assign store_beat = beat_fire && tag_match;
  // The first matching beat of an eviction decides full-line vs single-half.
  assign beat_all   = (mask_reg == 2'b00) ? bus.sc_wbu_all_offset : all_offset_reg;
  assign mask_upd   = mask_reg | (bus.sc_wbu_offset ? 2'b10 : 2'b01);
  assign line_done  = beat_all ? (mask_upd == 2'b11) : 1'b1;
  assign aw_left    = aw_pend_reg && !bus.wbu_axi3_awready;
  assign w_left     = w_pend_reg && !bus.wbu_axi3_wready;
  assign b_fire     = (state == RESP) && bus.wbu_axi3_bvalid;
  assign id_w       = {{(ID_WIDTH-6){1'b0}}, set_way_reg};
  assign b_bad      = (bus.wbu_axi3_bresp != 2'b00) || (bus.wbu_axi3_bid != id_w);

  // Half-line buffers. Each half is cleared when a request is accepted, so an
  // unfilled half always reads as zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    logic [HALF_W-1:0] data_reg;
    logic              hit;

    assign hit = store_beat && (bus.sc_wbu_offset == 1'(gi));

    // Capture this half from a matching beat; a duplicate half overwrites it.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        data_reg <= '0;
      end else if (req_fire) begin
        data_reg <= '0;
      end else if (hit) begin
        data_reg <= bus.sc_wbu_data;
      end
    end

    assign wdata_w[gi*HALF_W +: HALF_W] = data_reg;
    assign wstrb_w[gi*HALF_B +: HALF_B] = {HALF_B{mask_reg[gi]}};
  end

`ifdef WBU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] timeout_cnt_reg;
`endif

  // Eviction FSM: request latch, beat collection, AW/W issue, B wait.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      addr_reg       <= '0;
      set_way_reg    <= '0;
      mask_reg       <= 2'b00;
      all_offset_reg <= 1'b0;
      aw_pend_reg    <= 1'b0;
      w_pend_reg     <= 1'b0;
      err_reg        <= 1'b0;
`ifdef WBU_TIMEOUT_EN
      timeout_cnt_reg <= '0;
`endif
    end else begin
      err_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.htu_wbu_awvalid) begin
            addr_reg    <= bus.htu_wbu_awaddr;
            set_way_reg <= bus.htu_wbu_set_way;
            mask_reg    <= 2'b00;
            state       <= COLLECT;
          end
        end
        COLLECT: begin
          if (beat_fire) begin
            if (!tag_match) begin
              // A beat for another victim is consumed and dropped.
              err_reg <= 1'b1;
            end else begin
              if (mask_reg == 2'b00) begin
                all_offset_reg <= bus.sc_wbu_all_offset;
              end
              mask_reg <= mask_upd;
              if (line_done) begin
                aw_pend_reg <= 1'b1;
                w_pend_reg  <= 1'b1;
                state       <= SEND;
              end
            end
          end
        end
        SEND: begin
          // AW and W may complete in either order or in the same cycle.
          if (bus.wbu_axi3_awready) aw_pend_reg <= 1'b0;
          if (bus.wbu_axi3_wready)  w_pend_reg  <= 1'b0;
          if (!aw_left && !w_left) begin
            state <= RESP;
`ifdef WBU_TIMEOUT_EN
            timeout_cnt_reg <= '0;
`endif
          end
        end
        RESP: begin
          if (bus.wbu_axi3_bvalid) begin
            state <= IDLE;
`ifdef WBU_TIMEOUT_EN
          end else if (timeout_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_reg <= 1'b1;
            state   <= IDLE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.htu_wbu_awready  = (state == IDLE);
  assign bus.sc_wbu_ready     = (state == COLLECT);

  assign bus.wbu_axi3_awvalid = aw_pend_reg;
  assign bus.wbu_axi3_awid    = id_w;
  assign bus.wbu_axi3_awaddr  = {addr_reg, 5'b00000};
  assign bus.wbu_axi3_awlen   = 4'd0;
  assign bus.wbu_axi3_awsize  = 3'b101;
  assign bus.wbu_axi3_awburst = 2'b01;

  assign bus.wbu_axi3_wvalid  = w_pend_reg;
  assign bus.wbu_axi3_wid     = id_w;
  assign bus.wbu_axi3_wdata   = wdata_w;
  assign bus.wbu_axi3_wstrb   = wstrb_w;
  assign bus.wbu_axi3_wlast   = 1'b1;

  assign bus.wbu_axi3_bready  = (state == RESP);

  assign bus.wbu_busy = (state != IDLE);
  assign bus.wbu_done = b_fire;
  assign bus.wbu_err  = err_reg || (b_fire && b_bad);
endmodule

// File: doc/bank_biu_wbu.md
Name: bank_biu_wbu

Overview:
Write-back unit on the bank's dirty-eviction path, beside the refill BIU.
- Accepts one eviction request (line address plus set/way) from the HTU.
- Collects the victim line from the SRAM controller as two 128-bit halves and assembles one 256-bit AXI3 write line.
- Issues single-beat AW/W, waits for B, then frees itself for the next eviction.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 256, line and AXI data width (2 x 128-bit halves).
STRB_WIDTH, DATA_WIDTH/8, write strobe width.
ID_WIDTH, 8, AXI ID width.
TIMEOUT_CYCLES, 255, B-response watchdog limit; used only with WBU_TIMEOUT_EN.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, asynchronous, active-high.
htu_wbu_awvalid_i  in  1  eviction request.
htu_wbu_awready_o  out  1  request accepted; high only in IDLE.
htu_wbu_awaddr_i  in  ADDR_WIDTH-5  line address [ADDR_WIDTH-1:5].
htu_wbu_set_way_i  in  6  victim set/way tag.
sc_wbu_valid_i  in  1  SRAM half-line beat valid.
sc_wbu_ready_o  out  1  beat accepted; high only in COLLECT.
sc_wbu_data_i  in  128  half-line data.
sc_wbu_offset_i  in  1  0 = bytes 0-15, 1 = bytes 16-31.
sc_wbu_all_offset_i  in  1  1 = full line follows; 0 = this single half only.
sc_wbu_set_way_offset_i  in  7  {set_way, offset} tag of the beat.
wbu_axi3_aw*  out  -  awvalid, awid[ID_WIDTH], awaddr[ADDR_WIDTH], awlen[4], awsize[3], awburst[2]; awready in.
wbu_axi3_w*  out  -  wvalid, wid[ID_WIDTH], wdata[DATA_WIDTH], wstrb[STRB_WIDTH], wlast; wready in.
wbu_axi3_bvalid_i  in  1  write response valid.
wbu_axi3_bready_o  out  1  response accept.
wbu_axi3_bid_i  in  ID_WIDTH  response ID.
wbu_axi3_bresp_i  in  2  response code.
wbu_busy_o  out  1  state != IDLE.
wbu_done_o  out  1  one-cycle pulse on the B handshake.
wbu_err_o  out  1  one-cycle pulse on an error event.

Behaviour:
- States: IDLE, COLLECT, SEND, RESP.
- Reset (async): state IDLE; awvalid/wvalid/bready/done/err/busy all 0; htu_wbu_awready_o=1; half-mask cleared. Reset in any state aborts the transaction and drops buffered data.
- IDLE: on awvalid&awready, latch addr and set_way; next state COLLECT, mask=2'b00.
- COLLECT: on each sc valid&ready:
  - Tag check: beat tag[6:1] must equal the latched set_way.
  - Mismatched tag: beat is consumed, not stored, err pulses next cycle.
  - First matching beat latches all_offset.
  - Data goes to half sc_wbu_offset_i; the mask bit is set.
  - A duplicate half overwrites the stored half.
  - Complete when mask==2'b11 (all_offset=1) or one half held (all_offset=0). Next cycle enters SEND.
- SEND: awvalid and wvalid both held until each handshakes; completions tracked independently, either order or same cycle. After both complete, next state RESP.
- Fixed AW/W fields:
  - awid = wid = {2'b00, set_way}.
  - awaddr = {addr, 5'b0}; awlen=0; awsize=3'b101; awburst=2'b01; wlast=1.
  - wstrb = 32'hFFFFFFFF for a full line; 32'h0000FFFF (offset 0) or 32'hFFFF0000 (offset 1) for a single half.
- RESP: bready=1.
  - On bvalid: done=1 that cycle; next state IDLE.
  - err=1 that cycle if bresp!=2'b00 or bid != awid.
- Latency, back-to-back beats, always-ready bus: AW accept at cycle T; beats at T+1, T+2; AW/W handshake at T+3; earliest B at T+4; awready high again at T+5.

Optional Feature:
WBU_TIMEOUT_EN
- Defined: a counter clears on RESP entry and increments each RESP cycle. When it reaches TIMEOUT_CYCLES without bvalid: err pulses, state returns to IDLE, done stays 0. A late B is ignored while in IDLE (bready=0).
- Not defined: no counter; RESP waits indefinitely.

Test Plan:
- Full line: addr 0x0000_1234, set_way 0x15, beats offset0=A, offset1=B, all_offset=1 -> awaddr=0x0000_1220, awid=0x15, wdata={B,A}, wstrb all ones, done after bresp=0.
- Single half: offset 1, all_offset=0 -> one beat accepted, wstrb=32'hFFFF0000, SEND on the next cycle.
- Out-of-order halves (offset1 then offset0) plus a mismatched-tag beat between them -> mismatched beat dropped with one err pulse; line assembled correctly.
- AW ready 3 cycles before W ready, then the reverse -> each valid held until its own handshake; RESP entered only after both.
- bresp=2'b10 -> done=1 and err=1 in the same cycle; rst_i asserted mid-COLLECT -> IDLE, awready=1, no AXI valid.
- WBU_TIMEOUT_EN, TIMEOUT_CYCLES=4, bvalid never asserted -> err pulse after 4 RESP cycles, IDLE, done=0.
